// File: rtl/system_state_pkg.sv
// Shared state encodings for the status path; the LED controller decodes
// system_state with these same constants.
package system_state_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_NORMAL  = 2'b01,
        ST_WARNING = 2'b10,
        ST_FAULT   = 2'b11
    } state_e;

endpackage : system_state_pkg

// File: rtl/persist_counter.sv
// Saturating run-length counter: hit flags the valid sample whose condition
// completes a run of PERSIST consecutive qualifying samples.
module persist_counter #(
    parameter int PERSIST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic valid,
    input  logic cond,
    output logic hit
);

    localparam int               CNT_W   = $clog2(PERSIST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERSIST);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(PERSIST - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // hit depends only on the registered count, never on clr, so the top's
    // transition logic can feed clr back without forming a loop.
    assign hit = valid && cond && (cnt_q >= CNT_PRE);

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (valid) begin
            if (!cond) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : persist_counter

// File: rtl/system_state_fsm.sv
// Qualifies monitor samples against warning/fault thresholds with persistence
// and hysteresis, producing the registered system_state for the LED path.
module system_state_fsm
    import system_state_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int WARN_TH  = 2048,
    parameter int FAULT_TH = 3072,
    parameter int HYST     = 64,
    parameter int PERSIST  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic              fault_clr,
    output logic [1:0]        system_state,
    output logic              state_chg,
    output logic [7:0]        fault_cnt
);

    localparam logic [DATA_W-1:0] WARN_LVL  = DATA_W'(WARN_TH);
    localparam logic [DATA_W-1:0] FAULT_LVL = DATA_W'(FAULT_TH);
    localparam logic [DATA_W-1:0] LOW_LVL   = DATA_W'(WARN_TH - HYST);

    state_e     state_q, state_d;
    logic       state_chg_q;
    logic [7:0] fault_cnt_q;

    logic is_fault, is_high, is_low;
    logic flt_hit, hi_hit, lo_hit;
    logic cnt_clr;

    assign is_fault = (sample >= FAULT_LVL);
    assign is_high  = (sample >= WARN_LVL);
    assign is_low   = (sample <  LOW_LVL);

    // Runs restart on any state change and never accumulate in IDLE or FAULT.
    assign cnt_clr = (state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_FAULT);

    persist_counter #(.PERSIST(PERSIST)) u_flt_cnt (
        .clk(clk), .reset(reset), .clr(cnt_clr), .valid(sample_valid), .cond(is_fault), .hit(flt_hit)
    );

    persist_counter #(.PERSIST(PERSIST)) u_hi_cnt (
        .clk(clk), .reset(reset), .clr(cnt_clr), .valid(sample_valid), .cond(is_high), .hit(hi_hit)
    );

    persist_counter #(.PERSIST(PERSIST)) u_lo_cnt (
        .clk(clk), .reset(reset), .clr(cnt_clr), .valid(sample_valid), .cond(is_low), .hit(lo_hit)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_NORMAL;
            end
            ST_NORMAL: begin
                if (!enable)      state_d = ST_IDLE;
                else if (flt_hit) state_d = ST_FAULT;
                else if (hi_hit)  state_d = ST_WARNING;
            end
            ST_WARNING: begin
                if (!enable)      state_d = ST_IDLE;
                else if (flt_hit) state_d = ST_FAULT;
                else if (lo_hit)  state_d = ST_NORMAL;
            end
            ST_FAULT: begin
                // Latched: only an explicit clear releases it, enable is ignored.
                if (fault_clr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            state_chg_q <= 1'b0;
            fault_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            state_chg_q <= (state_d != state_q);
            if ((state_d == ST_FAULT) && (state_q != ST_FAULT) && (fault_cnt_q != 8'hFF)) begin
                fault_cnt_q <= fault_cnt_q + 8'd1;
            end
        end
    end

    assign system_state = state_q;
    assign state_chg    = state_chg_q;
    assign fault_cnt    = fault_cnt_q;

endmodule : system_state_fsm

// File: tb/tb_system_state_fsm.sv
// Directed and randomized checks of system_state_fsm against a run-length
// reference model built from the threshold/persistence rules.
module tb_system_state_fsm;

    localparam int DATA_W   = 12;
    localparam int WARN_TH  = 2048;
    localparam int FAULT_TH = 3072;
    localparam int HYST     = 64;
    localparam int PERSIST  = 4;

    localparam int M_IDLE    = 0;
    localparam int M_NORMAL  = 1;
    localparam int M_WARNING = 2;
    localparam int M_FAULT   = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic              fault_clr;
    logic [1:0]        system_state;
    logic              state_chg;
    logic [7:0]        fault_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain run lengths of consecutive qualifying samples.
    int m_state, m_flt, m_hi, m_lo, m_fcnt;
    int m_chg;
    int cur_class;

    system_state_fsm #(
        .DATA_W(DATA_W), .WARN_TH(WARN_TH), .FAULT_TH(FAULT_TH), .HYST(HYST), .PERSIST(PERSIST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .sample_valid(sample_valid),
        .sample(sample),
        .fault_clr(fault_clr),
        .system_state(system_state),
        .state_chg(state_chg),
        .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = M_IDLE;
        m_flt   = 0;
        m_hi    = 0;
        m_lo    = 0;
        m_fcnt  = 0;
        m_chg   = 0;
    endfunction

    function automatic void model_step(input bit en, input bit v, input int s, input bit clr);
        int prev, nxt, nf, nh, nl;
        prev = m_state;
        nxt  = prev;
        nf   = m_flt;
        nh   = m_hi;
        nl   = m_lo;
        if (prev == M_IDLE) begin
            if (en) nxt = M_NORMAL;
        end else if (prev == M_FAULT) begin
            if (clr) nxt = M_IDLE;
        end else if (!en) begin
            nxt = M_IDLE;
        end else if (v) begin
            nf = (s >= FAULT_TH)       ? m_flt + 1 : 0;
            nh = (s >= WARN_TH)        ? m_hi + 1  : 0;
            nl = (s < WARN_TH - HYST)  ? m_lo + 1  : 0;
            if (nf >= PERSIST)                           nxt = M_FAULT;
            else if (prev == M_NORMAL  && nh >= PERSIST) nxt = M_WARNING;
            else if (prev == M_WARNING && nl >= PERSIST) nxt = M_NORMAL;
        end
        if (nxt != prev || nxt == M_IDLE || nxt == M_FAULT) begin
            nf = 0;
            nh = 0;
            nl = 0;
        end
        m_flt = nf;
        m_hi  = nh;
        m_lo  = nl;
        m_chg = (nxt != prev) ? 1 : 0;
        if (nxt == M_FAULT && prev != M_FAULT && m_fcnt < 255) m_fcnt++;
        m_state = nxt;
    endfunction

    task automatic step(input bit en, input bit v, input int s, input bit clr);
        enable       = en;
        sample_valid = v;
        sample       = DATA_W'(s);
        fault_clr    = clr;
        @(posedge clk);
        model_step(en, v, s, clr);
        #1;
        check("state", 32'(system_state), 32'(m_state));
        check("chg",   32'(state_chg),    32'(m_chg));
        check("fcnt",  32'(fault_cnt),    32'(m_fcnt));
    endtask

    // Asserts reset mid-cycle and checks that outputs clear without a clock edge.
    task automatic async_reset();
        #3;
        reset = 1'b1;
        #1;
        check("rst_state", 32'(system_state), 32'd0);
        check("rst_chg",   32'(state_chg),    32'd0);
        check("rst_fcnt",  32'(fault_cnt),    32'd0);
        model_reset();
        enable       = 1'b0;
        sample_valid = 1'b0;
        fault_clr    = 1'b0;
        @(posedge clk);
        #1;
        check("rst_hold", 32'(system_state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic go_fault();
        repeat (PERSIST) step(1'b1, 1'b1, 3100, 1'b0);
    endtask

    task automatic recover();
        step(1'b1, 1'b0, 0, 1'b1);
        step(1'b1, 1'b0, 0, 1'b0);
    endtask

    function automatic int rand_sample();
        int bnd[6];
        bnd = '{1983, 1984, 2047, 2048, 3071, 3072};
        if ($urandom_range(0, 4) == 0) cur_class = int'($urandom_range(0, 4));
        case (cur_class)
            0:       return int'($urandom_range(0, 1983));
            1:       return int'($urandom_range(1984, 2047));
            2:       return int'($urandom_range(2048, 3071));
            3:       return int'($urandom_range(3072, 4095));
            default: return bnd[$urandom_range(0, 5)];
        endcase
    endfunction

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        fault_clr    = 1'b0;
        cur_class    = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_state", 32'(system_state), 32'd0);
        check("init_chg",   32'(state_chg),    32'd0);
        check("init_fcnt",  32'(fault_cnt),    32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Enable moves IDLE -> NORMAL with a single state_chg pulse.
        step(1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);
        check("t1_normal", 32'(system_state), 32'd1);
        check("t1_pulse",  32'(state_chg),    32'd1);
        step(1'b1, 1'b0, 0, 1'b0);
        check("t1_pulse_end", 32'(state_chg), 32'd0);

        // A mid-band sample breaks the high run.
        step(1'b1, 1'b1, 2100, 1'b0);
        step(1'b1, 1'b1, 2100, 1'b0);
        step(1'b1, 1'b1, 2000, 1'b0);
        step(1'b1, 1'b1, 2100, 1'b0);
        check("t2_no_warn", 32'(system_state), 32'd1);
        step(1'b1, 1'b1, 1000, 1'b0);
        repeat (3) step(1'b1, 1'b1, 2100, 1'b0);
        check("t2_pre_warn", 32'(system_state), 32'd1);
        step(1'b1, 1'b1, 2100, 1'b0);
        check("t2_warn", 32'(system_state), 32'd2);

        // Hysteresis: 1990 is not low, 1983 is.
        repeat (4) step(1'b1, 1'b1, 1990, 1'b0);
        check("t3_hold_warn", 32'(system_state), 32'd2);
        repeat (4) step(1'b1, 1'b1, 1983, 1'b0);
        check("t3_normal", 32'(system_state), 32'd1);

        // Fault-level samples with valid gaps escalate straight to FAULT.
        for (int i = 0; i < PERSIST; i++) begin
            step(1'b1, 1'b1, 3100, 1'b0);
            if (i < PERSIST - 1) begin
                check("t4_pre_fault", 32'(system_state), 32'd1);
                step(1'b1, 1'b0, 4095, 1'b0);
                step(1'b1, 1'b0, 0, 1'b0);
            end
        end
        check("t4_fault", 32'(system_state), 32'd3);
        check("t4_fcnt",  32'(fault_cnt),    32'd1);

        // FAULT survives disable; clear drops to IDLE for one cycle.
        repeat (3) step(1'b0, 1'b0, 0, 1'b0);
        check("t5_latched", 32'(system_state), 32'd3);
        step(1'b1, 1'b0, 0, 1'b1);
        check("t5_idle", 32'(system_state), 32'd0);
        step(1'b1, 1'b0, 0, 1'b0);
        check("t5_normal", 32'(system_state), 32'd1);

        // Async reset while latched in FAULT with fault_cnt = 3.
        go_fault();
        recover();
        go_fault();
        check("t6_fcnt3", 32'(fault_cnt), 32'd3);
        async_reset();

        // A partial fault run must not survive reset.
        step(1'b1, 1'b0, 0, 1'b0);
        repeat (PERSIST - 1) step(1'b1, 1'b1, 3500, 1'b0);
        async_reset();
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 3500, 1'b0);
        check("t6_cnt_clear", 32'(system_state), 32'd1);

        // Randomized traffic with occasional async resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 19) != 0,
                     $urandom_range(0, 9) < 7,
                     rand_sample(),
                     $urandom_range(0, 19) == 0);
            end
        end

        // fault_cnt saturates at 255.
        async_reset();
        step(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 257; i++) begin
            go_fault();
            recover();
        end
        check("fcnt_sat", 32'(fault_cnt), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_system_state_fsm
